// File: rtl/ps2_tx_ctrl.sv
// PS/2 host-to-device transmit sequencer: inhibit, request-to-send, bit shift
// on device clock falls, ACK sampling, with a watchdog on the device clock.
`timescale 1ns/1ps
module ps2_tx_ctrl #(
  parameter int INHIBIT_CYC = 6000,
  parameter int RTS_CYC     = 100,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk50m,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  output logic       clk_oe,
  output logic       clk_od,
  output logic       dat_oe,
  output logic       dat_od,
  input  logic       clk_id,
  input  logic       dat_id
);

  localparam int CNT_TOP = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_TOP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_ACK, S_WAIT_IDLE, S_ABORT
  } state_t;

  state_t        r_state;
  logic          r_clk_s, r_clk_s_d, r_dat_s;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_n;
  logic [7:0]    r_data;
  logic          r_par;
  logic          r_tx_ready, r_tx_done, r_tx_err, r_busy;
  logic          r_clk_oe, r_clk_od, r_dat_oe, r_dat_od;

  logic          w_fall, w_accept, w_timeout;
  logic [CW-1:0] w_cnt_inc;

  assign w_fall    = r_clk_s_d & ~r_clk_s;
  assign w_accept  = tx_valid & r_tx_ready;
  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + {{(CW-1){1'b0}}, 1'b1};
  // The ABORT cycle and the tx_err register use the last two cycles of the budget,
  // so tx_err lands exactly TIMEOUT_CYC cycles after the last reference point.
  assign w_timeout = (r_cnt >= CW'(TIMEOUT_CYC - 2));

  // Line input synchroniser and edge-detect history; lines idle high.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      r_clk_s   <= 1'b1;
      r_clk_s_d <= 1'b1;
      r_dat_s   <= 1'b1;
    end else begin
      r_clk_s   <= clk_id;
      r_clk_s_d <= r_clk_s;
      r_dat_s   <= dat_id;
    end
  end

  // Transfer sequencer with registered pad controls and handshake outputs.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_n        <= 4'd0;
      r_data     <= 8'h00;
      r_par      <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tx_err   <= 1'b0;
      r_busy     <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_clk_od   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_dat_od   <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data     <= tx_data;
            r_par      <= ~^tx_data;
            r_cnt      <= '0;
            r_clk_oe   <= 1'b1;
            r_clk_od   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_dat_od   <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == CW'(INHIBIT_CYC - 1)) begin
            r_cnt    <= '0;
            r_dat_oe <= 1'b1;
            r_dat_od <= 1'b0;
            r_state  <= S_RTS;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RTS: begin
          if (r_cnt == CW'(RTS_CYC - 1)) begin
            r_cnt    <= '0;
            r_n      <= 4'd0;
            r_clk_oe <= 1'b0;
            r_state  <= S_SEND;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_SEND: begin
          if (w_fall) begin
            r_cnt <= '0;
            r_n   <= r_n + 4'd1;
            if (r_n == 4'd9) begin
              r_dat_oe <= 1'b0;
              r_dat_od <= 1'b0;
              r_state  <= S_WAIT_ACK;
            end else if (r_n == 4'd8) begin
              r_dat_od <= r_par;
            end else begin
              r_dat_od <= r_data[r_n[2:0]];
            end
          end else if (w_timeout) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_dat_od <= 1'b0;
            r_state  <= S_ABORT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_ACK: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_state <= r_dat_s ? S_ABORT : S_WAIT_IDLE;
          end else if (w_timeout) begin
            r_state <= S_ABORT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_IDLE: begin
          if (r_clk_s && r_dat_s) begin
            r_cnt      <= '0;
            r_tx_done  <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_fall) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_state <= S_ABORT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_ABORT: begin
          r_cnt      <= '0;
          r_clk_oe   <= 1'b0;
          r_dat_oe   <= 1'b0;
          r_dat_od   <= 1'b0;
          r_tx_err   <= 1'b1;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_cnt      <= '0;
          r_clk_oe   <= 1'b0;
          r_dat_oe   <= 1'b0;
          r_dat_od   <= 1'b0;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready = r_tx_ready;
  assign tx_done  = r_tx_done;
  assign tx_err   = r_tx_err;
  assign busy     = r_busy;
  assign clk_oe   = r_clk_oe;
  assign clk_od   = r_clk_od;
  assign dat_oe   = r_dat_oe;
  assign dat_od   = r_dat_od;

endmodule

// File: doc/ps2_tx_ctrl.md
# ps2_tx_ctrl

Host-to-device transmit sequencer for the PS/2 keyboard interface. It drives the output-enable and output-data controls of the two `tri_state` pad buffers (PS/2 clock and PS/2 data) and reads back their registered inputs. It performs the inhibit / request-to-send / bit-shift / acknowledge protocol for one command byte at a time (e.g. 0xED set-LEDs, 0xFF reset). While a transfer is in progress it owns both lines, and `busy` tells the receive path to ignore line activity.

## Interface
- `INHIBIT_CYC`, 6000: clock-low inhibit time in `clk50m` cycles (120 µs).
- `RTS_CYC`, 100: data-low-before-clock-release time in cycles (2 µs).
- `TIMEOUT_CYC`, 1000000: maximum cycles between device clock falling edges (20 ms).
- `clk50m`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_valid`  in  1  command byte available.
- `tx_data`  in  8  command byte, LSB sent first.
- `tx_ready`  out  1  block idle, can accept a byte.
- `tx_done`  out  1  one-cycle pulse: byte sent and acknowledged.
- `tx_err`  out  1  one-cycle pulse: no ACK or timeout.
- `busy`  out  1  transfer in progress; receive path must ignore the lines.
- `clk_oe`, `clk_od`  out  1 each  to PS/2 clock `tri_state` `oe` / `od`.
- `dat_oe`, `dat_od`  out  1 each  to PS/2 data `tri_state` `oe` / `od`.
- `clk_id`, `dat_id`  in  1 each  from `tri_state` `id` (already registered once).

## Operation
- **Input synchronisation.** `clk_id` and `dat_id` pass through one more flop each, giving `clk_s` and `dat_s`.
- **Falling-edge detect.** `fall = clk_s_d & ~clk_s`, where `clk_s_d` is `clk_s` delayed one cycle.
- **Accept.** A byte is accepted when `tx_valid & tx_ready`. On accept, latch `tx_data` and odd parity `p = ~^tx_data`. `tx_valid` is ignored when `tx_ready` = 0.
- **States:**
  - **IDLE.** All `oe` = 0; `tx_ready` = 1; `busy` = 0. Goes to INHIBIT on accept.
  - **INHIBIT.** `clk_oe` = 1, `clk_od` = 0, `dat_oe` = 0. Held for `INHIBIT_CYC` cycles, then RTS.
  - **RTS.** Clock still low; `dat_oe` = 1, `dat_od` = 0 (start bit). Held for `RTS_CYC` cycles. Then `clk_oe` = 0, bit index `n` = 0, go to SEND.
  - **SEND.** On each `fall`:
    - `n` = 0..7: drive data bit `n`.
    - `n` = 8: drive parity `p`.
    - `n` = 9: `dat_oe` = 0 (stop bit released high), go to WAIT_ACK.
    - `n` increments on each `fall`.
  - **WAIT_ACK.** On the next `fall`, sample `dat_s`. If 0, go to WAIT_IDLE. If 1, go to ABORT.
  - **WAIT_IDLE.** Wait for `clk_s` = 1 and `dat_s` = 1 together. Then pulse `tx_done` and go to IDLE.
  - **ABORT.** All `oe` = 0. Pulse `tx_err`, go to IDLE.
- **Timeout.** The counter resets on entry to SEND and on every `fall`. In SEND, WAIT_ACK and WAIT_IDLE, reaching `TIMEOUT_CYC` sends the block to ABORT.
- **Busy.** `busy` = 1 in every state except IDLE.
- **`od` values while released.** `dat_od` and `clk_od` are don't-care while their `oe` = 0. The block holds them at 0.
- **Counter widths.**
  - `n`: 4 bits.
  - Delay/timeout counter: `$clog2(max(INHIBIT_CYC, TIMEOUT_CYC)+1)` bits, saturating.

## Timing
- **Reset values** (asynchronous): state IDLE, `tx_ready` = 1, `busy` = 0, `tx_done` = 0, `tx_err` = 0, `clk_oe` = 0, `clk_od` = 0, `dat_oe` = 0, `dat_od` = 0, all counters 0.
- **Reset mid-transfer.** Releases both lines immediately. No `tx_done` or `tx_err` is issued.
- **Registered outputs.** All outputs are registered.
- **Accept to line low.** `clk_oe` = 1 on the cycle after accept. The pad follows one cycle later, through the `tri_state` output flop.
- **Sampling latency.** Pad to `fall` is 3 cycles (tri_state flop, sync flop, edge flop). All device-clock timing is measured from `fall`.
- **Data setup.** The new data bit appears on `dat_od` one cycle after `fall`. The device samples on its rising edge at least 30 µs later, so this latency is harmless.
- **ACK and timeout on the same cycle.** The ACK sample takes priority.
- **Spurious `fall` during INHIBIT or RTS.** Ignored.
- **End of transfer.** `tx_done` or `tx_err` goes high in the same cycle that `tx_ready` returns to 1.
- **Accept at end of transfer.** Accepting a new byte in that same cycle is allowed: the next transfer starts immediately.

## Test plan
- **Normal send of 0xED.** Device model clocks at 12.5 kHz and acks.
  - Data line sequence: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1, then ACK 0.
  - Clock held low ≥ 6000 cycles first.
  - One `tx_done` pulse, no `tx_err`.
- **Send 0x07.** Parity bit observed = 0. Send 0x00: parity = 1.
- **No ACK.** Device leaves data high on the 11th clock. Expect `tx_err` pulse one cycle after the sampling `fall` plus the ABORT state, all `oe` = 0, `tx_ready` = 1.
- **Device never clocks.** `tx_err` occurs exactly `TIMEOUT_CYC` cycles after SEND entry (use a reduced parameter in the bench), and both lines are released.
- **`tx_valid` held during a transfer with changing `tx_data`.** Only the first byte is transmitted. Second byte accepted in the `tx_done` cycle: the second transfer's INHIBIT starts the next cycle.
- **`rst` asserted at bit 4.** Outputs return to their reset values without waiting for a clock edge. A new send after reset completes normally.
